// File: rtl/jpeg_pkg.sv
// jpeg_pkg
//   Shared definitions for the JPEG MCU scheduler slice: block-phase state
//   encodings, channel index constants, the default block size and a helper
//   that turns the grayscale flag into a channel-activity mask.
package jpeg_pkg;

  localparam int BLK_PIX_DEF = 64;

  localparam int CH_Y  = 0;
  localparam int CH_CB = 1;
  localparam int CH_CR = 2;

  localparam logic [2:0] ST_LOAD    = 3'd0;
  localparam logic [2:0] ST_DRAIN   = 3'd1;
  localparam logic [2:0] ST_DCT     = 3'd2;
  localparam logic [2:0] ST_DCT_END = 3'd3;
  localparam logic [2:0] ST_ZIGZAG  = 3'd4;
  localparam logic [2:0] ST_ZZ_WAIT = 3'd5;
  localparam logic [2:0] ST_HUFF    = 3'd6;
  localparam logic [2:0] ST_EMIT    = 3'd7;

  // Grayscale keeps only luminance alive; colour keeps every channel.
  function automatic logic [3:0] act_mask(input logic gray);
    return gray ? 4'b0001 : 4'b1111;
  endfunction

endpackage

// File: rtl/jpeg_code_mux.sv
// jpeg_code_mux
//   Selects one per-channel Huffman code stream and forwards it to the merged
//   output; the downstream ready is steered back to the selected channel only.
//   Ports:
//     en_i          forwarding enabled (scheduler in its emit phase)
//     sel_i         channel being forwarded
//     code_valid_i  per-channel code available
//     code_last_i   per-channel last-code flag
//     code_i        packed codes, channel i at [i*CODE_W +: CODE_W]
//     len_i         packed code lengths, same packing
//     ready_i       downstream accept
//     code_ready_o  per-channel pop, only on the selected channel
//     valid_o       merged valid
//     last_o        last flag of the selected channel
//     code_o/len_o  selected code and length
module jpeg_code_mux #(
  parameter int NUM_CH = 3,
  parameter int CODE_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic                     en_i,
  input  logic [1:0]               sel_i,
  input  logic [NUM_CH-1:0]        code_valid_i,
  input  logic [NUM_CH-1:0]        code_last_i,
  input  logic [NUM_CH*CODE_W-1:0] code_i,
  input  logic [NUM_CH*LEN_W-1:0]  len_i,
  input  logic                     ready_i,
  output logic [NUM_CH-1:0]        code_ready_o,
  output logic                     valid_o,
  output logic                     last_o,
  output logic [CODE_W-1:0]        code_o,
  output logic [LEN_W-1:0]         len_o
);

  always_comb begin
    code_ready_o = '0;
    valid_o      = 1'b0;
    last_o       = 1'b0;
    code_o       = '0;
    len_o        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_i == 2'(i)) begin
        valid_o         = en_i & code_valid_i[i];
        last_o          = code_last_i[i];
        code_o          = code_i[i*CODE_W +: CODE_W];
        len_o           = len_i[i*LEN_W +: LEN_W];
        code_ready_o[i] = en_i & ready_i;
      end
    end
  end

endmodule

// File: rtl/jpeg_mcu_scheduler.sv
// jpeg_mcu_scheduler
//   Block-level sequencer for the per-channel JPEG encoders. Accepts BLK_PIX
//   pixels, strobes the channel loads behind the colour converter, runs the
//   DCT / zigzag / Huffman phases, then merges each channel's code stream in
//   channel order into one ready/valid output.
//   Ports:
//     clock, reset_n       clock, asynchronous active-low reset
//     gray_mode            luminance-only block, taken at the block's first pixel
//     pix_valid/pix_ready  pixel handshake (ready only while loading)
//     ch_load_en           per-channel load strobe, aligned to converter output
//     ch_dct_en/_dct_end   DCT run enable and end pulse
//     ch_zz_en             zigzag pulse
//     ch_huff_start        Huffman start pulse
//     ch_code_*            per-channel code streams and their pop
//     out_*                merged code stream, source channel, block-end flag
//     blk_count            completed blocks, wrapping
module jpeg_mcu_scheduler
  import jpeg_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int BLK_PIX  = BLK_PIX_DEF,
  parameter int CONV_LAT = 1,
  parameter int DCT_CYC  = 8,
  parameter int ZZ_CYC   = 4,
  parameter int CODE_W   = 16,
  parameter int LEN_W    = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     gray_mode,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [NUM_CH-1:0]        ch_load_en,
  output logic [NUM_CH-1:0]        ch_dct_en,
  output logic [NUM_CH-1:0]        ch_dct_end,
  output logic [NUM_CH-1:0]        ch_zz_en,
  output logic [NUM_CH-1:0]        ch_huff_start,
  input  logic [NUM_CH-1:0]        ch_code_valid,
  input  logic [NUM_CH-1:0]        ch_code_last,
  input  logic [NUM_CH*CODE_W-1:0] ch_code,
  input  logic [NUM_CH*LEN_W-1:0]  ch_code_len,
  output logic [NUM_CH-1:0]        ch_code_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CODE_W-1:0]        out_code,
  output logic [LEN_W-1:0]         out_len,
  output logic [1:0]               out_ch,
  output logic                     out_blk_last,
  output logic [15:0]              blk_count
);

  logic [2:0]  state_q, state_d;
  logic [6:0]  pix_cnt_q, pix_cnt_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic [1:0]  cur_ch_q, cur_ch_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic        gray_q, gray_d;
  logic        dct_en_q, dct_end_q, zz_q, huff_q;

  logic              pix_hs, load_strobe;
  logic              mux_valid, mux_last, code_hs;
  logic [1:0]        last_ch;
  logic [3:0]        act_full, act_ld_full;
  logic [NUM_CH-1:0] act, act_ld, mux_ready;

  assign pix_ready = (state_q == ST_LOAD);
  assign pix_hs    = pix_valid & pix_ready;

  assign act_full    = act_mask(gray_q);
  assign act         = act_full[NUM_CH-1:0];
  // With no converter latency the first strobe coincides with the pixel that
  // sets the mask, so load strobes look at the mask being latched.
  assign act_ld_full = act_mask(gray_d);
  assign act_ld      = act_ld_full[NUM_CH-1:0];

  // Active channels are always a contiguous run from luminance, so the last
  // active channel is either 0 (grayscale) or the top channel.
  assign last_ch = gray_q ? 2'd0 : 2'(NUM_CH - 1);

  generate
    if (CONV_LAT == 0) begin : g_no_lat
      assign load_strobe = pix_hs;
    end else begin : g_lat
      logic [CONV_LAT-1:0] load_sr_q;
      // Delay line matching the colour converter so each load strobe meets
      // the converted pixel.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          load_sr_q <= '0;
        end else begin
          load_sr_q[0] <= pix_hs;
          for (int i = 1; i < CONV_LAT; i++) load_sr_q[i] <= load_sr_q[i-1];
        end
      end
      assign load_strobe = load_sr_q[CONV_LAT-1];
    end
  endgenerate

  jpeg_code_mux #(
    .NUM_CH (NUM_CH),
    .CODE_W (CODE_W),
    .LEN_W  (LEN_W)
  ) u_code_mux (
    .en_i         (state_q == ST_EMIT),
    .sel_i        (cur_ch_q),
    .code_valid_i (ch_code_valid),
    .code_last_i  (ch_code_last),
    .code_i       (ch_code),
    .len_i        (ch_code_len),
    .ready_i      (out_ready),
    .code_ready_o (mux_ready),
    .valid_o      (mux_valid),
    .last_o       (mux_last),
    .code_o       (out_code),
    .len_o        (out_len)
  );

  assign code_hs       = mux_valid & out_ready;
  assign out_valid     = mux_valid;
  assign out_ch        = cur_ch_q;
  assign out_blk_last  = mux_valid & mux_last & (cur_ch_q == last_ch);
  assign ch_code_ready = mux_ready & act;
  assign ch_load_en    = load_strobe ? act_ld : '0;
  assign ch_dct_en     = dct_en_q  ? act : '0;
  assign ch_dct_end    = dct_end_q ? act : '0;
  assign ch_zz_en      = zz_q      ? act : '0;
  assign ch_huff_start = huff_q    ? act : '0;
  assign blk_count     = blk_cnt_q;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    cur_ch_d  = cur_ch_q;
    blk_cnt_d = blk_cnt_q;
    gray_d    = gray_q;
    if (pix_hs && pix_cnt_q == 7'd0) gray_d = gray_mode;
    case (state_q)
      ST_LOAD: begin
        if (pix_hs) begin
          if (pix_cnt_q == 7'(BLK_PIX - 1)) begin
            pix_cnt_d = '0;
            cyc_cnt_d = '0;
            state_d   = (CONV_LAT == 0) ? ST_DCT : ST_DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + 7'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (cyc_cnt_q == 16'(CONV_LAT - 1)) begin
          cyc_cnt_d = '0;
          state_d   = ST_DCT;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end
      ST_DCT: begin
        if (cyc_cnt_q == 16'(DCT_CYC - 1)) begin
          cyc_cnt_d = '0;
          state_d   = ST_DCT_END;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end
      ST_DCT_END: state_d = ST_ZIGZAG;
      ST_ZIGZAG:  state_d = ST_ZZ_WAIT;
      ST_ZZ_WAIT: begin
        if (cyc_cnt_q == 16'(ZZ_CYC - 1)) begin
          cyc_cnt_d = '0;
          state_d   = ST_HUFF;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end
      ST_HUFF: begin
        state_d  = ST_EMIT;
        cur_ch_d = 2'(CH_Y);
      end
      ST_EMIT: begin
        if (code_hs && mux_last) begin
          if (cur_ch_q == last_ch) begin
            state_d   = ST_LOAD;
            blk_cnt_d = blk_cnt_q + 16'd1;
          end else begin
            cur_ch_d = cur_ch_q + 2'd1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Phase outputs decode the next state so each is high exactly while the
  // scheduler sits in the matching state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_LOAD;
      pix_cnt_q <= '0;
      cyc_cnt_q <= '0;
      cur_ch_q  <= '0;
      blk_cnt_q <= '0;
      gray_q    <= 1'b0;
      dct_en_q  <= 1'b0;
      dct_end_q <= 1'b0;
      zz_q      <= 1'b0;
      huff_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      cur_ch_q  <= cur_ch_d;
      blk_cnt_q <= blk_cnt_d;
      gray_q    <= gray_d;
      dct_en_q  <= (state_d == ST_DCT);
      dct_end_q <= (state_d == ST_DCT_END);
      zz_q      <= (state_d == ST_ZIGZAG);
      huff_q    <= (state_d == ST_HUFF);
    end
  end

endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// tb_jpeg_mcu_scheduler
//   Drives whole blocks of pixels into the scheduler, models three channel
//   code sources as queues, and checks the merged output beat by beat against
//   a scoreboard of expected beats, plus phase timing and reset behaviour.
module tb_jpeg_mcu_scheduler;
  import jpeg_pkg::*;

  localparam int NUM_CH   = 3;
  localparam int CONV_LAT = 1;
  localparam int DCT_CYC  = 8;
  localparam int ZZ_CYC   = 4;
  localparam int CODE_W   = 16;
  localparam int LEN_W    = 8;
  localparam int NPIX     = 64;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
    logic              last;
  } chItem_t;

  typedef struct packed {
    logic [1:0]        ch;
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
    logic              blkLast;
  } beat_t;

  logic                     clock, reset_n, gray_mode, pix_valid, pix_ready;
  logic [NUM_CH-1:0]        ch_load_en, ch_dct_en, ch_dct_end, ch_zz_en, ch_huff_start;
  logic [NUM_CH-1:0]        ch_code_valid, ch_code_last, ch_code_ready;
  logic [NUM_CH*CODE_W-1:0] ch_code;
  logic [NUM_CH*LEN_W-1:0]  ch_code_len;
  logic                     out_valid, out_ready, out_blk_last;
  logic [CODE_W-1:0]        out_code;
  logic [LEN_W-1:0]         out_len;
  logic [1:0]               out_ch;
  logic [15:0]              blk_count;

  jpeg_mcu_scheduler #(
    .NUM_CH(NUM_CH), .BLK_PIX(NPIX), .CONV_LAT(CONV_LAT), .DCT_CYC(DCT_CYC),
    .ZZ_CYC(ZZ_CYC), .CODE_W(CODE_W), .LEN_W(LEN_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .gray_mode(gray_mode),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ch_load_en(ch_load_en), .ch_dct_en(ch_dct_en), .ch_dct_end(ch_dct_end),
    .ch_zz_en(ch_zz_en), .ch_huff_start(ch_huff_start),
    .ch_code_valid(ch_code_valid), .ch_code_last(ch_code_last),
    .ch_code(ch_code), .ch_code_len(ch_code_len), .ch_code_ready(ch_code_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_len(out_len), .out_ch(out_ch), .out_blk_last(out_blk_last),
    .blk_count(blk_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  chItem_t chQ [NUM_CH][$];
  beat_t   sb[$];

  // Per-block stimulus policy and observations
  logic blkGray, gapMode, toggleReady, dropPending, emitDone;
  int   pixLeft, pixSent, cycleNo, blkNo, expBlk;
  int   firstHsCycle, lastHsCycle, firstLoadCycle, dctFirst;
  int   loadCnt, dctCnt, endCnt, zzCnt, huffCnt, endCycle, zzCycle, huffCycle;
  logic [NUM_CH-1:0] loadOr, dctOr, endOr, zzOr, huffOr;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveChannels();
    chItem_t it;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chQ[i].size() > 0) begin
        it = chQ[i][0];
        ch_code_valid[i] = 1'b1;
        ch_code_last[i]  = it.last;
        ch_code[i*CODE_W +: CODE_W] = it.code;
        ch_code_len[i*LEN_W +: LEN_W] = it.len;
      end else begin
        ch_code_valid[i] = 1'b0;
        ch_code_last[i]  = 1'b0;
        ch_code[i*CODE_W +: CODE_W] = '0;
        ch_code_len[i*LEN_W +: LEN_W] = '0;
      end
    end
  endtask

  task automatic clearStats();
    firstHsCycle = 0; lastHsCycle = 0; firstLoadCycle = 0; dctFirst = 0;
    loadCnt = 0; dctCnt = 0; endCnt = 0; zzCnt = 0; huffCnt = 0;
    endCycle = 0; zzCycle = 0; huffCycle = 0;
    loadOr = '0; dctOr = '0; endOr = '0; zzOr = '0; huffOr = '0;
    pixSent = 0; dropPending = 1'b0; emitDone = 1'b0;
  endtask

  // One clock: drive on the falling edge, observe shortly after, before the
  // next rising edge commits the handshakes seen here.
  task automatic applyStimulus();
    beat_t exp;
    @(negedge clock);
    pix_valid = (pixLeft > 0) && (!gapMode || ($urandom_range(0, 3) != 0));
    gray_mode = (pixSent == 0) ? blkGray : ~blkGray;
    out_ready = toggleReady ? ~out_ready : 1'b1;
    driveChannels();
    #2;
    cycleNo++;
    if (dropPending) begin
      checkOutput("pix_ready_drop", 32'(pix_ready), 32'd0);
      dropPending = 1'b0;
    end
    if (pix_valid && pix_ready) begin
      if (pixSent == 0) firstHsCycle = cycleNo;
      lastHsCycle = cycleNo;
      pixSent++;
      pixLeft--;
      if (pixSent == NPIX) dropPending = 1'b1;
    end
    if (|ch_load_en) begin
      if (loadCnt == 0) firstLoadCycle = cycleNo;
      loadCnt++;
      loadOr |= ch_load_en;
    end
    if (|ch_dct_en) begin
      if (dctCnt == 0) dctFirst = cycleNo;
      dctCnt++;
      dctOr |= ch_dct_en;
    end
    if (|ch_dct_end) begin endCnt++; endOr |= ch_dct_end; endCycle = cycleNo; end
    if (|ch_zz_en) begin zzCnt++; zzOr |= ch_zz_en; zzCycle = cycleNo; end
    if (|ch_huff_start) begin huffCnt++; huffOr |= ch_huff_start; huffCycle = cycleNo; end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        checkOutput("out_ch", 32'(out_ch), 32'(exp.ch));
        checkOutput("out_code", 32'(out_code), 32'(exp.code));
        checkOutput("out_len", 32'(out_len), 32'(exp.len));
        checkOutput("out_blk_last", 32'(out_blk_last), 32'(exp.blkLast));
        if (exp.blkLast) emitDone = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++)
      if (ch_code_valid[i] && ch_code_ready[i]) void'(chQ[i].pop_front());
  endtask

  task automatic checkBlock(input logic [NUM_CH-1:0] expMask);
    checkOutput("load_count", 32'(loadCnt), NPIX);
    checkOutput("load_mask", 32'(loadOr), 32'(expMask));
    checkOutput("load_offset", 32'(firstLoadCycle - firstHsCycle), CONV_LAT);
    checkOutput("dct_cycles", 32'(dctCnt), DCT_CYC);
    checkOutput("dct_mask", 32'(dctOr), 32'(expMask));
    checkOutput("dct_latency", 32'(dctFirst - lastHsCycle), CONV_LAT + 1);
    checkOutput("dct_end_pulses", 32'(endCnt), 32'd1);
    checkOutput("dct_end_time", 32'(endCycle - dctFirst), DCT_CYC);
    checkOutput("dct_end_mask", 32'(endOr), 32'(expMask));
    checkOutput("zz_pulses", 32'(zzCnt), 32'd1);
    checkOutput("zz_time", 32'(zzCycle - endCycle), 32'd1);
    checkOutput("zz_mask", 32'(zzOr), 32'(expMask));
    checkOutput("huff_pulses", 32'(huffCnt), 32'd1);
    checkOutput("huff_overhead", 32'(huffCycle - lastHsCycle),
                CONV_LAT + DCT_CYC + ZZ_CYC + 3);
    checkOutput("huff_mask", 32'(huffOr), 32'(expMask));
    checkOutput("blk_count", 32'(blk_count), 32'(expBlk));
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic runBlock(input logic gray, input logic gaps, input logic toggle,
                          input int n0, input int n1, input int n2);
    int n[NUM_CH];
    int lastActive;
    int cyc;
    chItem_t it;
    beat_t bt;
    logic [NUM_CH-1:0] expMask;
    n[CH_Y] = n0; n[CH_CB] = n1; n[CH_CR] = n2;
    blkNo++;
    clearStats();
    blkGray = gray; gapMode = gaps; toggleReady = toggle; pixLeft = NPIX;
    expMask = gray ? 3'b001 : 3'b111;
    lastActive = gray ? CH_Y : CH_CR;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < n[c]; k++) begin
        it.code = {4'(blkNo), 4'(c), 8'(k)};
        it.len  = 8'(1 + ((k * 5 + c * 3) % 16));
        it.last = (k == n[c] - 1);
        chQ[c].push_back(it);
        if (expMask[c]) begin
          bt.ch = 2'(c); bt.code = it.code; bt.len = it.len;
          bt.blkLast = it.last && (c == lastActive);
          sb.push_back(bt);
        end
      end
    end
    expBlk = (expBlk + 1) % 65536;
    cyc = 0;
    while (!emitDone && cyc < 3000) begin
      applyStimulus();
      cyc++;
    end
    if (!emitDone) checkOutput("block_timeout", 32'd0, 32'd1);
    applyStimulus();
    checkOutput("pix_ready_rise", 32'(pix_ready), 32'd1);
    checkBlock(expMask);
    if (gray) begin
      checkOutput("ch1_pending", 32'(chQ[CH_CB].size()), 32'(n1));
      checkOutput("ch2_pending", 32'(chQ[CH_CR].size()), 32'(n2));
      chQ[CH_CB].delete();
      chQ[CH_CR].delete();
    end
  endtask

  task automatic resetMidBlock();
    int cyc;
    clearStats();
    blkGray = 1'b0; gapMode = 1'b0; toggleReady = 1'b0; pixLeft = 30;
    cyc = 0;
    while (pixSent < 30 && cyc < 500) begin
      applyStimulus();
      cyc++;
    end
    checkOutput("partial_pixels", 32'(pixSent), 32'd30);
    pixLeft = 0;
    @(negedge clock);
    pix_valid = 1'b0;
    checkOutput("pre_reset_load", 32'(ch_load_en), 32'b111);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_pix_ready", 32'(pix_ready), 32'd1);
    checkOutput("rst_load_en", 32'(ch_load_en), 32'd0);
    checkOutput("rst_dct_en", 32'(ch_dct_en), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_code_ready", 32'(ch_code_ready), 32'd0);
    checkOutput("rst_blk_count", 32'(blk_count), 32'd0);
    expBlk = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; gray_mode = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
    ch_code_valid = '0; ch_code_last = '0; ch_code = '0; ch_code_len = '0;
    cycleNo = 0; blkNo = 0; expBlk = 0; pixLeft = 0;
    blkGray = 1'b0; gapMode = 1'b0; toggleReady = 1'b0;
    clearStats();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    checkOutput("reset_pix_ready", 32'(pix_ready), 32'd1);
    checkOutput("reset_load_en", 32'(ch_load_en), 32'd0);
    checkOutput("reset_phases", 32'({ch_dct_en, ch_dct_end, ch_zz_en, ch_huff_start}), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_blk_count", 32'(blk_count), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] colour block, 5/3/2 codes, ready held high");
    runBlock(1'b0, 1'b0, 1'b0, 5, 3, 2);
    $display("[TB] grayscale block, channels 1/2 left pending");
    runBlock(1'b1, 1'b0, 1'b0, 4, 3, 3);
    $display("[TB] colour block with pixel gaps and toggling ready");
    runBlock(1'b0, 1'b1, 1'b1, 6, 4, 5);
    $display("[TB] reset after 30 pixels");
    resetMidBlock();
    runBlock(1'b0, 1'b1, 1'b0, 2, 2, 2);
    runBlock(1'b0, 1'b0, 1'b1, 1, 3, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_mcu_scheduler.md
# jpeg_mcu_scheduler

Parametrised control and output-arbitration block for the multi-channel JPEG encoder datapath. It replaces the externally driven phase pins (input / DCT / DCT-end / zigzag / Huffman-start) with an internal block-level state machine that drives NUM_CH per-channel encoder instances, and supports a grayscale mode. It merges the per-channel Huffman code streams into one ready/valid stream in channel order (Y, Cb, Cr, …). It sits between the pixel source / RGB-to-YCbCr converter and the per-channel encoder instances.

## Interface
- NUM_CH, 3, number of colour channels (1..4); channel 0 is luminance
- BLK_PIX, 64, pixels per block
- CONV_LAT, 1, colour-converter latency in cycles (0..4)
- DCT_CYC, 8, cycles dct_enable is held per block (≥1)
- ZZ_CYC, 4, wait cycles after the zigzag pulse (≥1)
- CODE_W, 16, Huffman code width
- LEN_W, 8, code-length width

- clock  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- gray_mode  in  1  1 = only channel 0 active; sampled on the first accepted pixel of a block
- pix_valid  in  1  pixel offered (RGB to converter in parallel)
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready
- ch_load_en  out  NUM_CH  per-channel pixel-load strobe, aligned to converter output
- ch_dct_en  out  NUM_CH  DCT run enable
- ch_dct_end  out  NUM_CH  one-cycle DCT-end pulse
- ch_zz_en  out  NUM_CH  one-cycle zigzag-input pulse
- ch_huff_start  out  NUM_CH  one-cycle Huffman-start pulse
- ch_code_valid  in  NUM_CH  per-channel code available
- ch_code_last  in  NUM_CH  last code of this channel's block
- ch_code  in  NUM_CH*CODE_W  codes; channel i at bits [i*CODE_W +: CODE_W]
- ch_code_len  in  NUM_CH*LEN_W  code lengths, packed the same way
- ch_code_ready  out  NUM_CH  per-channel pop
- out_valid  out  1  merged code valid
- out_ready  in  1  downstream accept
- out_code  out  CODE_W  merged code
- out_len  out  LEN_W  merged code length
- out_ch  out  2  source channel index
- out_blk_last  out  1  last code of the last active channel in the block
- blk_count  out  16  completed-block counter

## Operation
- Active mask `act` is latched on the first accepted pixel: all ones when gray_mode = 0, 1 (channel 0 only) when gray_mode = 1. Every per-channel output is ANDed with `act`.
- State sequence: LOAD → DRAIN → DCT → DCT_END → ZIGZAG → ZZ_WAIT → HUFF → EMIT → LOAD.
- LOAD: pix_ready = 1. A 7-bit pixel counter increments per handshake. After the BLK_PIX-th handshake: go to DRAIN, or straight to DCT when CONV_LAT = 0.
- DRAIN: waits CONV_LAT cycles so that the last ch_load_en is issued.
- ch_load_en is the handshake delayed by CONV_LAT cycles through a shift register.
- DCT: ch_dct_en high for exactly DCT_CYC cycles.
- DCT_END, ZIGZAG, HUFF: one cycle each, pulsing ch_dct_end, ch_zz_en and ch_huff_start respectively.
- ZZ_WAIT: ZZ_CYC cycles.
- EMIT: cur_ch starts at the lowest active channel.
  - Mux: out_valid = ch_code_valid[cur_ch]; ch_code_ready[cur_ch] = out_ready; all other ch_code_ready = 0. out_code, out_len and out_ch come from cur_ch.
  - On a handshake with ch_code_last[cur_ch] = 1, advance to the next active channel.
  - When the current channel is the last active one: assert out_blk_last on that beat, increment blk_count (wraps at 0xFFFF → 0), and return to LOAD.
- Only the codes from cur_ch are forwarded; codes from other channels remain pending.
- pix_valid while not in LOAD: ignored (pix_ready = 0).
- gray_mode changes mid-block: no effect until the next block's first pixel.

## Timing
- Reset values:
  - State LOAD, so pix_ready = 1 during and after reset.
  - Counters 0, act all ones, load shift register 0.
  - All per-channel outputs 0, out_valid 0, blk_count 0.
- Reset mid-block returns to LOAD at once; partial pixels and codes are discarded, with no pulses emitted.
- Phase outputs are registered: a pulse is high in the cycle after the state is entered and lasts exactly one cycle.
- Load-to-DCT latency: the first ch_dct_en cycle comes CONV_LAT+1 cycles after the last pixel handshake.
- Control overhead from last pixel handshake to ch_huff_start: CONV_LAT + DCT_CYC + ZZ_CYC + 3 cycles, excluding EMIT.
- EMIT path is combinational pass-through (no added latency). Merged throughput is 1 code/cycle when out_ready is high.
- pix_ready drops in the cycle after the BLK_PIX-th handshake.
- pix_ready rises again in the cycle after the final EMIT handshake.

## Structure
- Shared package jpeg_pkg: state enumeration, channel index constants (CH_Y = 0, CH_CB = 1, CH_CR = 2), BLK_PIX default.
- One sub-module, jpeg_code_mux: the per-channel code stream selector (cur_ch → out, ready demux). The FSM and counters stay in the top.

## Test plan
- NUM_CH = 3, CONV_LAT = 1, 64 pixels back to back → ch_load_en = 3'b111 for 64 cycles, offset 1 cycle. dct_en for 8 cycles, then single pulses on dct_end, zz and huff_start.
- Emit with channels supplying 5/3/2 codes, out_ready always 1 → 10 out beats with out_ch 0,0,0,0,0,1,1,1,2,2; out_blk_last on beat 10; blk_count = 1.
- gray_mode = 1 at the first pixel → all phase outputs and ch_load_en equal 3'b001. After channel 0's last code, state returns to LOAD; codes pending on channels 1/2 are never popped.
- out_ready toggling 1010… plus random pix_valid gaps → no code is lost or duplicated, and exactly 64 load strobes occur.
- reset_n asserted after 30 pixels → every output reaches its reset value immediately. The next block needs a full 64 pixels before ch_dct_en rises.
- blk_count preloaded near wrap (run 65536 blocks with a short-DCT configuration) → value 0xFFFF followed by 0x0000.
